// File: rtl/fp_sample_gain_seq.sv
// Sequencer that drives one shared fpUnit through I2F -> MUL -> ADD -> F2I for each
// accepted audio sample, computing y = int(float(x) * gain + bias). The result is
// saturated to DW bits and presented on a valid/ready output.
module fp_sample_gain_seq #(
    parameter int unsigned DW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_sample_i,
    input  logic [31:0]   gain_i,
    input  logic [31:0]   bias_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_sample_o,
    output logic          busy_o,
    output logic          timeout_err_o,
    output logic          fp_clk_en_o,
    output logic [2:0]    fp_operation_o,
    output logic [31:0]   fp_dataa_o,
    output logic [31:0]   fp_datab_o,
    input  logic [31:0]   fp_result_i,
    input  logic          fp_done_i
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpMul = 3'd3;
    localparam logic [2:0] OpF2i = 3'd4;
    localparam logic [2:0] OpI2f = 3'd5;

    localparam int unsigned     CntW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    // Clamp bounds for a DW-bit signed result; for DW=32 they span the full range.
    localparam logic signed [31:0] SatMax = 32'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [31:0] SatMin = ~SatMax;

    typedef enum logic [2:0] {
        StIdle,
        StI2f,
        StMul,
        StAdd,
        StF2i,
        StGap,
        StOut
    } state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            fp_clk_en_q, fp_clk_en_d;
    logic [2:0]      fp_op_q, fp_op_d;
    logic [31:0]     fp_dataa_q, fp_dataa_d;
    logic [31:0]     fp_datab_q, fp_datab_d;
    logic [31:0]     gain_q, gain_d;
    logic [31:0]     bias_q, bias_d;
    logic [31:0]     res_q, res_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic [DW-1:0]   out_sample_q, out_sample_d;
    logic [DW-1:0]   sat_val;

    // Saturate the last captured fpUnit result (the F2I integer) to DW bits.
    always_comb begin
        if ($signed(res_q) > SatMax) begin
            sat_val = SatMax[DW-1:0];
        end else if ($signed(res_q) < SatMin) begin
            sat_val = SatMin[DW-1:0];
        end else begin
            sat_val = res_q[DW-1:0];
        end
    end

    // Next-state logic: accept, run each fpUnit op, insert gaps, timeout and output handshake.
    always_comb begin
        state_d       = state_q;
        fp_clk_en_d   = fp_clk_en_q;
        fp_op_d       = fp_op_q;
        fp_dataa_d    = fp_dataa_q;
        fp_datab_d    = fp_datab_q;
        gain_d        = gain_q;
        bias_d        = bias_q;
        res_d         = res_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
        out_sample_d  = out_sample_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i && in_ready_q) begin
                    gain_d      = gain_i;
                    bias_d      = bias_i;
                    fp_dataa_d  = 32'(signed'(in_sample_i));
                    fp_datab_d  = 32'h0;
                    fp_op_d     = OpI2f;
                    fp_clk_en_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StI2f;
                end
            end
            StI2f, StMul, StAdd, StF2i: begin
                if (fp_clk_en_q && fp_done_i) begin
                    res_d       = fp_result_i;
                    fp_clk_en_d = 1'b0;
                    state_d     = StGap;
                end else if (fp_clk_en_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntMax) begin
                        // Abort the sample: no output, flag sticks until reset.
                        fp_clk_en_d   = 1'b0;
                        timeout_err_d = 1'b1;
                        cnt_d         = '0;
                        state_d       = StIdle;
                    end
                end
            end
            StGap: begin
                // The opcode still held on the port says which op just finished.
                case (fp_op_q)
                    OpI2f: begin
                        fp_op_d     = OpMul;
                        fp_dataa_d  = res_q;
                        fp_datab_d  = gain_q;
                        fp_clk_en_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StMul;
                    end
                    OpMul: begin
                        fp_op_d     = OpAdd;
                        fp_dataa_d  = res_q;
                        fp_datab_d  = bias_q;
                        fp_clk_en_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StAdd;
                    end
                    OpAdd: begin
                        fp_op_d     = OpF2i;
                        fp_dataa_d  = res_q;
                        fp_datab_d  = 32'h0;
                        fp_clk_en_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StF2i;
                    end
                    default: begin
                        out_sample_d = sat_val;
                        state_d      = StOut;
                    end
                endcase
            end
            StOut: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_ready_d = (state_d == StIdle);
    end

    // State and datapath registers; reset drops fp_clk_en at once and discards any sample.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StIdle;
            in_ready_q    <= 1'b0;
            fp_clk_en_q   <= 1'b0;
            fp_op_q       <= 3'd0;
            fp_dataa_q    <= 32'h0;
            fp_datab_q    <= 32'h0;
            gain_q        <= 32'h0;
            bias_q        <= 32'h0;
            res_q         <= 32'h0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            out_sample_q  <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            fp_clk_en_q   <= fp_clk_en_d;
            fp_op_q       <= fp_op_d;
            fp_dataa_q    <= fp_dataa_d;
            fp_datab_q    <= fp_datab_d;
            gain_q        <= gain_d;
            bias_q        <= bias_d;
            res_q         <= res_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            out_sample_q  <= out_sample_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign out_valid_o    = (state_q == StOut);
    assign out_sample_o   = out_sample_q;
    assign busy_o         = (state_q != StIdle);
    assign timeout_err_o  = timeout_err_q;
    assign fp_clk_en_o    = fp_clk_en_q;
    assign fp_operation_o = fp_op_q;
    assign fp_dataa_o     = fp_dataa_q;
    assign fp_datab_o     = fp_datab_q;

endmodule

// File: tb/tb_fp_sample_gain_seq.sv
// Bench for fp_sample_gain_seq: the bench plays the fpUnit, checks every opcode and
// operand it is handed against a table of hand-computed IEEE-754 values, and returns
// the table's results with varying latencies.
module tb_fp_sample_gain_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sample;
    logic [31:0] gain;
    logic [31:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        busy;
    logic        timeout_err;
    logic        fp_clk_en;
    logic [2:0]  fp_operation;
    logic [31:0] fp_dataa;
    logic [31:0] fp_datab;
    logic [31:0] fp_result;
    logic        fp_done;

    int total = 0;
    int bad   = 0;
    int n;

    typedef struct packed {
        logic [15:0] x;
        logic [31:0] gain;
        logic [31:0] bias;
        logic [31:0] r0;  // I2F result
        logic [31:0] r1;  // MUL result
        logic [31:0] r2;  // ADD result
        logic [31:0] r3;  // F2I result
        logic [15:0] y;   // expected saturated output
    } vec_t;

    vec_t vecs [7];

    fp_sample_gain_seq #(
        .DW             (16),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock_i        (clock),
        .reset_ni       (reset_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_sample_i    (in_sample),
        .gain_i         (gain),
        .bias_i         (bias),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_sample_o   (out_sample),
        .busy_o         (busy),
        .timeout_err_o  (timeout_err),
        .fp_clk_en_o    (fp_clk_en),
        .fp_operation_o (fp_operation),
        .fp_dataa_o     (fp_dataa),
        .fp_datab_o     (fp_datab),
        .fp_result_i    (fp_result),
        .fp_done_i      (fp_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a sample at a negedge; returns on the negedge after the accept edge.
    task automatic accept(input vec_t v);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_sample = v.x;
        gain      = v.gain;
        bias      = v.bias;
        @(negedge clock);
        in_valid  = 1'b0;
        in_sample = 16'h5A5A;
        gain      = 32'hFFFF_FFFF;
        bias      = 32'hFFFF_FFFF;
    endtask

    // Serve one fpUnit operation; called on the negedge where it must already be active.
    task automatic run_op(input string nm, input logic [2:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat,
                          input bit spur);
        int unstable = 0;
        check({nm, "_clk_en"}, fp_clk_en, 1);
        check({nm, "_opcode"}, fp_operation, opc);
        check({nm, "_dataa"}, fp_dataa, a);
        check({nm, "_datab"}, fp_datab, b);
        check({nm, "_busy"}, busy, 1);
        check({nm, "_in_ready"}, in_ready, 0);
        for (int i = 1; i < lat; i++) begin
            @(negedge clock);
            if (fp_clk_en !== 1'b1 || fp_operation !== opc || fp_dataa !== a || fp_datab !== b)
                unstable++;
        end
        check({nm, "_stable"}, unstable, 0);
        fp_done   = 1'b1;
        fp_result = res;
        @(negedge clock);
        // A done pulse during the gap must be ignored.
        fp_done   = spur;
        fp_result = spur ? 32'hDEAD_BEEF : 32'h0;
        check({nm, "_gap"}, fp_clk_en, 0);
        @(negedge clock);
        fp_done   = 1'b0;
        fp_result = 32'h0;
    endtask

    task automatic finish_out(input logic [15:0] y, input int hold);
        int unstable = 0;
        check("out_valid", out_valid, 1);
        check("out_sample", out_sample, y);
        check("out_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'h1234;
            @(negedge clock);
            if (out_valid !== 1'b1 || out_sample !== y || in_ready !== 1'b0 || busy !== 1'b1 ||
                fp_clk_en !== 1'b0)
                unstable++;
        end
        check("out_hold_stable", unstable, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_clk_en", fp_clk_en, 0);
    endtask

    task automatic do_sample(input vec_t v, input int lat, input int lat_mul, input bit spur,
                             input int hold);
        accept(v);
        run_op("i2f", 3'd5, {{16{v.x[15]}}, v.x}, 32'h0, v.r0, lat, spur);
        run_op("mul", 3'd3, v.r0, v.gain, v.r1, lat_mul, spur);
        run_op("add", 3'd0, v.r1, v.bias, v.r2, lat, spur);
        run_op("f2i", 3'd4, v.r2, 32'h0, v.r3, lat, spur);
        finish_out(v.y, hold);
    endtask

    initial begin
        //          x         gain          bias          r0            r1            r2            r3            y
        vecs[0] = '{16'd100,  32'h40000000, 32'h00000000, 32'h42C80000, 32'h43480000, 32'h43480000,
                    32'h000000C8, 16'd200};
        vecs[1] = '{16'hFFF8, 32'h3F000000, 32'h41200000, 32'hC1000000, 32'hC0800000, 32'h40C00000,
                    32'h00000006, 16'd6};
        vecs[2] = '{16'd20000, 32'h40800000, 32'h00000000, 32'h469C4000, 32'h479C4000, 32'h479C4000,
                    32'h00013880, 16'h7FFF};
        vecs[3] = '{16'hB1E0, 32'h40800000, 32'h00000000, 32'hC69C4000, 32'hC79C4000, 32'hC79C4000,
                    32'hFFFEC780, 16'h8000};
        vecs[4] = '{16'h7FFF, 32'h3F800000, 32'h00000000, 32'h46FFFE00, 32'h46FFFE00, 32'h46FFFE00,
                    32'h00007FFF, 16'h7FFF};
        vecs[5] = '{16'h8000, 32'h3F800000, 32'hBF800000, 32'hC7000000, 32'hC7000000, 32'hC7000100,
                    32'hFFFF7FFF, 16'h8000};
        vecs[6] = '{16'h7FFF, 32'h3F800000, 32'h3F800000, 32'h46FFFE00, 32'h46FFFE00, 32'h47000000,
                    32'h00008000, 16'h7FFF};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sample = 16'h0;
        gain      = 32'h0;
        bias      = 32'h0;
        out_ready = 1'b0;
        fp_done   = 1'b0;
        fp_result = 32'h0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_clk_en", fp_clk_en, 0);
        check("rst_operation", fp_operation, 0);
        check("rst_dataa", fp_dataa, 0);
        check("rst_datab", fp_datab, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_in_ready", in_ready, 1);

        // Table-driven samples; the first one exercises 50 cycles of backpressure.
        for (int i = 0; i < 7; i++) begin
            do_sample(vecs[i], (i % 3) + 1, (i % 3) + 1, i[0], (i == 0) ? 50 : (i % 4));
        end

        // Done on the very cycle the counter reaches the limit wins: no error.
        do_sample(vecs[0], 1, 1024, 1'b0, 1);
        check("limit_no_err", timeout_err, 0);

        // MUL never completes: abort after exactly 1024 clk_en-high cycles.
        accept(vecs[0]);
        run_op("to_i2f", 3'd5, 32'd100, 32'h0, vecs[0].r0, 1, 1'b0);
        check("to_mul_opcode", fp_operation, 3);
        n = 0;
        while (fp_clk_en === 1'b1 && n < 1100) begin
            n++;
            @(negedge clock);
        end
        check("to_cycles", n, 1024);
        check("to_err", timeout_err, 1);
        check("to_in_ready", in_ready, 1);
        check("to_busy", busy, 0);
        check("to_out_valid", out_valid, 0);
        repeat (3) @(negedge clock);
        check("to_no_output", out_valid, 0);
        do_sample(vecs[1], 2, 2, 1'b0, 1);
        check("to_sticky", timeout_err, 1);

        // Async reset in the middle of ADD.
        accept(vecs[0]);
        run_op("r_i2f", 3'd5, 32'd100, 32'h0, vecs[0].r0, 1, 1'b0);
        run_op("r_mul", 3'd3, vecs[0].r0, vecs[0].gain, vecs[0].r1, 2, 1'b0);
        check("r_add_opcode", fp_operation, 0);
        #2 reset_n = 1'b0;
        #1;
        check("r_clk_en", fp_clk_en, 0);
        check("r_busy", busy, 0);
        check("r_out_valid", out_valid, 0);
        check("r_in_ready_low", in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("r_in_ready", in_ready, 1);
        check("r_err_cleared", timeout_err, 0);
        do_sample(vecs[0], 1, 1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
